// File: rtl/muldiv_unit_if.sv
// Request/response bundle between operand read, the RV32M multiply/divide unit and write-back.
// The master drives requests and flushes; the slave returns busy, the result strobe and its data.
interface muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
);
  logic                     start;
  logic [2:0]               funct3;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic [ADDRESS_WIDTH-1:0] rd_in;
  logic                     kill;
  logic                     busy;
  logic                     valid;
  logic [DATA_WIDTH-1:0]    result;
  logic [ADDRESS_WIDTH-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, kill,
    input  busy, valid, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, kill,
    output busy, valid, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, with sign correction on the final step.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned W        = DATA_WIDTH;
  localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                   state_q;
  logic [2:0]               funct3_q;
  logic [W-1:0]             opnd_q;    // multiplicand (mul) or divisor (div) magnitude
  logic [2*W-1:0]           acc_q;     // {product hi, multiplier} or {remainder, quotient}
  logic                     neg_q;
  logic [CntWidth-1:0]      cnt_q;
  logic [W-1:0]             result_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [ADDRESS_WIDTH-1:0] rd_out_q;

  // Request decode
  logic         signed_a, signed_b, a_neg, b_neg, is_div;
  logic         div_zero, div_ovf, special, start_neg;
  logic [W-1:0] mag_a, mag_b, special_res;

  assign signed_a  = !(bus.funct3 inside {3'b011, 3'b101, 3'b111});
  assign signed_b  = bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign a_neg     = signed_a && bus.op_a[W-1];
  assign b_neg     = signed_b && bus.op_b[W-1];
  assign mag_a     = a_neg ? -bus.op_a : bus.op_a;
  assign mag_b     = b_neg ? -bus.op_b : bus.op_b;
  assign is_div    = bus.funct3[2];
  assign div_zero  = is_div && (bus.op_b == '0);
  assign div_ovf   = is_div && !bus.funct3[0] && (bus.op_a == {1'b1, {(W-1){1'b0}}})
                     && (bus.op_b == '1);
  assign special   = div_zero || div_ovf;
  // Remainder follows the dividend's sign; products and quotients follow the sign xor.
  assign start_neg = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      special_res = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // Iteration step
  logic [W:0]     mul_sum, div_top, div_diff;
  logic [2*W-1:0] mul_next, div_next, acc_next, mul_fix;
  logic [W-1:0]   quo_fix, rem_fix, final_res;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[W-1:1]};
  assign div_top  = acc_q[2*W-1:W-1];
  assign div_diff = div_top - {1'b0, opnd_q};
  // A clear borrow bit means the shifted remainder covers the divisor.
  assign div_next = !div_diff[W] ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                                 : {acc_q[2*W-2:0], 1'b0};
  assign acc_next = funct3_q[2] ? div_next : mul_next;

  assign mul_fix = neg_q ? -acc_next : acc_next;
  assign quo_fix = neg_q ? -acc_next[W-1:0] : acc_next[W-1:0];
  assign rem_fix = neg_q ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];

  always_comb begin
    final_res = '0;
    case (funct3_q)
      3'b000:                 final_res = mul_fix[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = mul_fix[2*W-1:W];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.kill) begin
            funct3_q <= bus.funct3;
            rd_q     <= bus.rd_in;
            neg_q    <= start_neg;
            if (special) begin
              result_q <= special_res;
              rd_out_q <= bus.rd_in;
              state_q  <= StDone;
            end else begin
              opnd_q  <= is_div ? mag_b : mag_a;
              acc_q   <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
              cnt_q   <= CntWidth'(W);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (bus.kill) begin
            state_q <= StIdle;
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CntWidth'(1)) begin
              result_q <= final_res;
              rd_out_q <= rd_q;
              state_q  <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.valid  = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against a behavioural
// model, and hand sequences for start-while-busy, kill and mid-operation reset.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  muldiv_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) mdu_bus ();

  muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mdu_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at_cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[12];
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          sia, sib;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sia = a;
    sib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sia / sib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sia % sib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mdu_bus.valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", mdu_bus.result, e.res);
          check("rd_out", {27'b0, mdu_bus.rd_out}, {27'b0, e.rd});
          check("valid_cycle", 32'(cyc), 32'(e.at_cyc));
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (mdu_bus.busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'b0, mdu_bus.busy}, 32'd0);
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    mdu_bus.funct3 = f;
    mdu_bus.op_a   = a;
    mdu_bus.op_b   = b;
    mdu_bus.rd_in  = rd;
  endtask

  // Called one step after a rising edge with the unit idle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    drive(f, a, b, rd);
    mdu_bus.start = 1'b1;
    sb_q.push_back('{res: exp, rd: rd, at_cyc: cyc + 1 + lat});
    last_res = exp;
    last_rd  = rd;
    @(posedge clk); #1;
    mdu_bus.start = 1'b0;
    wait_idle("idle_after_op");
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        sp;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 32};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 32};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 32};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 32};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 32};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        32};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         32};
    vecs[8]  = '{3'b101, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 0};
    vecs[9]  = '{3'b110, 32'd5,         32'd0,         5'd10, 32'd5,         0};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0,         0};

    rst_n         = 1'b0;
    mdu_bus.start = 1'b0;
    mdu_bus.kill  = 1'b0;
    drive(3'b0, 32'b0, 32'b0, 5'b0);
    last_res = '0;
    last_rd  = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, mdu_bus.busy}, 32'd0);
    check("reset_valid", {31'b0, mdu_bus.valid}, 32'd0);
    check("reset_result", mdu_bus.result, 32'd0);
    check("reset_rd_out", {27'b0, mdu_bus.rd_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 24; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(0, 50);
        default: ;
      endcase
      sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      run_op(f, a, b, rd, model(f, a, b), sp ? 0 : 32);
    end

    // start held high through CALC and DONE: only the first request is taken
    drive(3'b000, 32'd1234, 32'd5678, 5'd17);
    mdu_bus.start = 1'b1;
    sb_q.push_back('{res: 32'd7006652, rd: 5'd17, at_cyc: cyc + 33});
    last_res = 32'd7006652;
    last_rd  = 5'd17;
    repeat (33) begin
      @(posedge clk); #1;
      drive(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
    end
    @(posedge clk); #1;
    mdu_bus.start = 1'b0;
    check("start_in_done_ignored", {31'b0, mdu_bus.busy}, 32'd0);
    run_op(3'b101, 32'd1000, 32'd3, 5'd18, 32'd333, 32);

    // kill on the tenth CALC edge: no strobe, outputs hold
    drive(3'b000, 32'd12345, 32'd678, 5'd21);
    mdu_bus.start = 1'b1;
    @(posedge clk); #1;
    mdu_bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    mdu_bus.kill = 1'b1;
    @(posedge clk); #1;
    mdu_bus.kill = 1'b0;
    check("kill_busy", {31'b0, mdu_bus.busy}, 32'd0);
    check("kill_result_hold", mdu_bus.result, last_res);
    check("kill_rd_hold", {27'b0, mdu_bus.rd_out}, {27'b0, last_rd});
    repeat (40) @(posedge clk);
    #1;

    // kill beats start in IDLE
    drive(3'b000, 32'd3, 32'd4, 5'd22);
    mdu_bus.start = 1'b1;
    mdu_bus.kill  = 1'b1;
    @(posedge clk); #1;
    mdu_bus.start = 1'b0;
    mdu_bus.kill  = 1'b0;
    check("kill_start_idle", {31'b0, mdu_bus.busy}, 32'd0);

    // asynchronous reset mid-operation
    drive(3'b101, 32'd999, 32'd4, 5'd23);
    mdu_bus.start = 1'b1;
    @(posedge clk); #1;
    mdu_bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, mdu_bus.busy}, 32'd0);
    check("midrst_valid", {31'b0, mdu_bus.valid}, 32'd0);
    check("midrst_result", mdu_bus.result, 32'd0);
    check("midrst_rd_out", {27'b0, mdu_bus.rd_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle", {31'b0, mdu_bus.busy}, 32'd0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd24, 32'hFFFF_FFFF, 32);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. Sits between register-file operand read and write-back: it consumes the two source operands, computes one of the eight M-extension results over 32 cycles, and presents result plus destination index with a one-cycle valid used as the register-file write enable. Raises busy so the pipeline control can stall issue while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
ADDRESS_WIDTH, 5, destination register index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_WIDTH  rs1 operand
op_b  input  DATA_WIDTH  rs2 operand
rd_in  input  ADDRESS_WIDTH  destination register of the request
kill  input  1  flush; aborts in-flight op, no valid produced
busy  output  1  high whenever state != IDLE
valid  output  1  one-cycle result strobe (write enable to register file)
result  output  DATA_WIDTH  registered result
rd_out  output  ADDRESS_WIDTH  registered destination index

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, valid=0, result=0, rd_out=0, counter=0, internal regs 0. Reset mid-operation discards the op; no valid after release.
- States: IDLE, CALC, DONE. busy is combinational from state; valid = (state==DONE).
- IDLE, start=1 at edge N: latch funct3, rd_in, operand magnitudes and result-sign flags; counter=DATA_WIDTH; go CALC. Exception: special divide cases go straight to DONE with result loaded at edge N (valid in cycle N..N+1, latency 1).
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; counter decrements; at edge where counter reaches 0 (edge N+32) final sign correction applied, result loaded, go DONE. Valid in cycle N+32..N+33.
- DONE: valid=1 for exactly one cycle, then IDLE. start during DONE is ignored; earliest accept is the edge after returning to IDLE.
- start while busy: ignored, no effect on in-flight op.
- kill=1 at any edge in CALC or DONE: go IDLE, valid never asserted for that op; result/rd_out keep previous values. kill has priority over start and over CALC->DONE transition. kill in IDLE with start=1: start ignored.
- Signedness: MUL/MULH/DIV/REM both signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned. Compute on magnitudes, negate at end.
- Multiply: 64-bit product; MUL returns low 32 bits, MULH/MULHSU/MULHU high 32 bits. Product negated (two's complement, 64-bit) iff operand signs differ.
- Divide: quotient negated iff signs differ; remainder takes sign of dividend.
- Divide by zero (op_b=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = op_a. Latency 1.
- Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000, REM result 0. Latency 1.
- Most-negative operand magnitude (0x80000000) handled with 33-bit/unsigned magnitude, no overflow in non-special cases.
- result and rd_out hold their value between strobes. rd_in=0 passed through unfiltered.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> busy 32 cycles, valid once at edge N+32, result 0xFFFFFFEB, rd_out = rd_in.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with valid one cycle after start; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- start re-asserted every cycle during an op -> ignored, exactly one valid; next op accepted only after DONE->IDLE.
- kill at cycle 10 of CALC -> IDLE, no valid, result unchanged; rst_n low at cycle 5 -> all outputs 0 immediately, no valid after release.
